// File: rtl/pe_mac_os.sv
// Output-stationary systolic MAC element: forwards A east and B south, multiplies
// in a MULT_STAGES-deep pipeline, accumulates locally and drains results westward.
module pe_mac_os #(
    parameter int DATA_W      = 16,
    parameter int ACC_W       = 40,
    parameter int MULT_STAGES = 2,
    parameter int SIGNED      = 1,
    parameter int SATURATE    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_first,
    input  logic              in_last,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              out_valid,
    output logic              out_first,
    output logic              out_last,
    input  logic [ACC_W-1:0]  res_in,
    input  logic              res_in_valid,
    output logic [ACC_W-1:0]  res_out,
    output logic              res_out_valid,
    output logic              sat_err,
    output logic              drop_err
);
    // Handshake: every *_valid is a pure one-cycle qualifier with no ready/backpressure;
    // data is consumed on any rising edge where its valid is high, ignored otherwise.

    localparam int PW = 2 * DATA_W;
    localparam logic [ACC_W-1:0] MAX_S = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MIN_S = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] MAX_U = {ACC_W{1'b1}};

    logic [PW-1:0]          w_prod;
    logic [PW-1:0]          r_prod [MULT_STAGES];
    logic [MULT_STAGES-1:0] r_vld;
    logic [MULT_STAGES-1:0] r_first;
    logic [MULT_STAGES-1:0] r_last;
    logic [ACC_W-1:0]       r_acc;
    logic [ACC_W-1:0]       r_buf;
    logic                   r_buf_full;
    logic [ACC_W-1:0]       w_prod_ext;
    logic [ACC_W-1:0]       w_acc_next;
    logic [ACC_W:0]         w_sum;
    logic                   w_acc_sx;
    logic                   w_ext_sx;
    logic                   w_ovf;
    logic                   w_sat_set;
    logic                   w_fin_vld;
    logic                   w_load;
    logic                   w_drain_local;

    generate
        if (SIGNED != 0) begin : g_signed
            assign w_prod     = PW'($signed(in_a)) * PW'($signed(in_b));
            assign w_prod_ext = ACC_W'($signed(r_prod[MULT_STAGES-1]));
        end else begin : g_unsigned
            assign w_prod     = PW'(in_a) * PW'(in_b);
            assign w_prod_ext = ACC_W'(r_prod[MULT_STAGES-1]);
        end
    endgenerate

    // One extra bit of headroom exposes overflow for both signed and unsigned modes.
    always_comb begin
        w_acc_sx   = (SIGNED != 0) ? r_acc[ACC_W-1] : 1'b0;
        w_ext_sx   = (SIGNED != 0) ? w_prod_ext[ACC_W-1] : 1'b0;
        w_sum      = {w_acc_sx, r_acc} + {w_ext_sx, w_prod_ext};
        w_ovf      = (SIGNED != 0) ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];
        w_sat_set  = 1'b0;
        w_acc_next = w_sum[ACC_W-1:0];
        if (r_first[MULT_STAGES-1]) begin
            w_acc_next = w_prod_ext;
        end else if (w_ovf) begin
            w_sat_set = 1'b1;
            if (SATURATE != 0) begin
                if (SIGNED != 0) begin
                    w_acc_next = w_sum[ACC_W] ? MIN_S : MAX_S;
                end else begin
                    w_acc_next = MAX_U;
                end
            end
        end
    end

    assign w_fin_vld     = r_vld[MULT_STAGES-1] & ~clr;
    assign w_load        = w_fin_vld & r_last[MULT_STAGES-1];
    assign w_drain_local = ~res_in_valid & r_buf_full & ~clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_a     <= '0;
            out_b     <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_a     <= in_a;
            out_b     <= in_b;
            out_valid <= in_valid;
            out_first <= in_first;
            out_last  <= in_last;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MULT_STAGES; i++) begin
                r_prod[i] <= '0;
            end
            r_vld   <= '0;
            r_first <= '0;
            r_last  <= '0;
        end else begin
            r_prod[0]  <= w_prod;
            r_vld[0]   <= in_valid & ~clr;
            r_first[0] <= in_first;
            r_last[0]  <= in_last;
            for (int i = 1; i < MULT_STAGES; i++) begin
                r_prod[i]  <= r_prod[i-1];
                r_vld[i]   <= r_vld[i-1] & ~clr;
                r_first[i] <= r_first[i-1];
                r_last[i]  <= r_last[i-1];
            end
        end
    end

    // Upstream results always win the bus; the local buffer waits for a free slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc         <= '0;
            r_buf         <= '0;
            r_buf_full    <= 1'b0;
            sat_err       <= 1'b0;
            drop_err      <= 1'b0;
            res_out       <= '0;
            res_out_valid <= 1'b0;
        end else begin
            if (clr) begin
                r_acc      <= '0;
                r_buf_full <= 1'b0;
                sat_err    <= 1'b0;
                drop_err   <= 1'b0;
            end else begin
                if (w_fin_vld) begin
                    r_acc <= w_acc_next;
                    if (w_sat_set) begin
                        sat_err <= 1'b1;
                    end
                end
                if (w_load) begin
                    r_buf      <= w_acc_next;
                    r_buf_full <= 1'b1;
                    if (r_buf_full && !w_drain_local) begin
                        drop_err <= 1'b1;
                    end
                end else if (w_drain_local) begin
                    r_buf_full <= 1'b0;
                end
            end
            if (res_in_valid) begin
                res_out       <= res_in;
                res_out_valid <= 1'b1;
            end else if (w_drain_local) begin
                res_out       <= r_buf;
                res_out_valid <= 1'b1;
            end else begin
                res_out_valid <= 1'b0;
            end
        end
    end
endmodule
